// File: rtl/mu0_defs.sv
// Shared definitions for the MU0 indexed core: sort sequencer states,
// memory read/write encoding, default datapath widths.
// No logic; consumed by sort_seq and sort_mem_xfer.
package mu0_defs;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 16;
  localparam int CW_DEF = 12;

  // mem_rnw encoding
  localparam logic MEM_RD = 1'b1;
  localparam logic MEM_WR = 1'b0;

  // Sort sequencer state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_A     = 3'd1;
  localparam logic [2:0] ST_RD_B     = 3'd2;
  localparam logic [2:0] ST_CMP      = 3'd3;
  localparam logic [2:0] ST_WR_LO    = 3'd4;
  localparam logic [2:0] ST_WR_HI    = 3'd5;
  localparam logic [2:0] ST_PASS_END = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_RD_A     = ST_RD_A,
    S_RD_B     = ST_RD_B,
    S_CMP      = ST_CMP,
    S_WR_LO    = ST_WR_LO,
    S_WR_HI    = ST_WR_HI,
    S_PASS_END = ST_PASS_END,
    S_DONE     = ST_DONE
  } sort_state_e;

  // 16-bit counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sort_mem_xfer.sv
// Memory request/acknowledge engine: one go pulse -> one transaction -> one ack pulse.
// Latency: request visible in the go cycle; ack pulse one cycle after mem_ack (that cycle is the mandatory idle gap).
// Backpressure: holds addr/rnw/wdata stable until mem_ack; caller must not pulse go while a transaction is pending.
module sort_mem_xfer import mu0_defs::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic          rnw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          pend,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          mem_rq,
  output logic          mem_rnw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  logic          rq_q, rq_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // The go cycle drives the bus straight from the caller so a zero-wait ack
  // can land in the first request cycle; later cycles come from the hold regs.
  assign mem_rq    = go | rq_q;
  assign mem_rnw   = go ? rnw   : rnw_q;
  assign mem_addr  = go ? addr  : addr_q;
  assign mem_wdata = go ? wdata : wdata_q;
  assign pend      = rq_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;

  // Capture request on go, retire on mem_ack; the ack pulse fills the idle gap
  always_comb begin
    rq_d    = rq_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    if (go) begin
      rnw_d   = rnw;
      addr_d  = addr;
      wdata_d = wdata;
    end
    if (mem_rq) begin
      if (mem_ack) begin
        rq_d  = 1'b0;
        ack_d = 1'b1;
        if (mem_rnw == MEM_RD) rdata_d = mem_rdata;
      end else begin
        rq_d = 1'b1;
      end
    end
  end

  // Hold registers; reset drops the request immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_q    <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rq_q    <= rq_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/sort_seq.sv
// In-memory bubble sort of signed words (optional SORT_EARLY_EXIT_EN: stop after a swap-free pass).
// Latency: 2 cycles for len<2; zero-wait memory costs 3 cycles per plain compare, 7 per swap.
// Backpressure: each memory state waits on mem_ack indefinitely; start ignored unless idle.
module sort_seq import mu0_defs::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [15:0]   swap_cnt,
  output logic          mem_rq,
  output logic          mem_rnw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  sort_state_e   state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] p_q, p_d;
  logic [CW-1:0] j_q, j_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          swp_q, swp_d;
  logic [15:0]   swap_cnt_q, swap_cnt_d;

  logic          x_go, x_rnw, x_pend, x_ack;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata, x_rdata;
  logic [AW-1:0] addr_j, addr_j1;
  logic          go_ok, adv, pass_stop;

  // Address arithmetic wraps modulo 2^AW by truncation
  assign addr_j  = base_q + AW'(j_q);
  assign addr_j1 = base_q + AW'(j_q) + AW'(1);
  assign go_ok   = !x_pend && !x_ack;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign swap_cnt = swap_cnt_q;

  sort_mem_xfer #(.AW(AW), .DW(DW)) u_xfer (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (x_go),
    .rnw       (x_rnw),
    .addr      (x_addr),
    .wdata     (x_wdata),
    .pend      (x_pend),
    .ack       (x_ack),
    .rdata     (x_rdata),
    .mem_rq    (mem_rq),
    .mem_rnw   (mem_rnw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // Next-state, datapath updates and memory commands for the sort sequence
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    p_d        = p_q;
    j_d        = j_q;
    a_d        = a_q;
    b_d        = b_q;
    swp_d      = swp_q;
    swap_cnt_d = swap_cnt_q;
    x_go       = 1'b0;
    x_rnw      = MEM_RD;
    x_addr     = base_q;
    x_wdata    = '0;
    adv        = 1'b0;
    pass_stop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base;
          p_d        = len - CW'(1);
          swap_cnt_d = '0;
          swp_d      = 1'b0;
          state_d    = (len < CW'(2)) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        x_go   = go_ok;
        x_addr = base_q;
        if (x_ack) begin
          a_d     = x_rdata;
          j_d     = '0;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        x_go   = go_ok;
        x_addr = addr_j1;
        if (x_ack) begin
          b_d     = x_rdata;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if ($signed(a_q) > $signed(b_q)) begin
          swp_d      = 1'b1;
          swap_cnt_d = sat_inc16(swap_cnt_q);
          state_d    = S_WR_LO;
        end else begin
          a_d = b_q;
          adv = 1'b1;
        end
      end
      S_WR_LO: begin
        x_go    = go_ok;
        x_rnw   = MEM_WR;
        x_addr  = addr_j;
        x_wdata = b_q;
        if (x_ack) state_d = S_WR_HI;
      end
      S_WR_HI: begin
        // A already holds the larger value and carries into the next compare
        x_go    = go_ok;
        x_rnw   = MEM_WR;
        x_addr  = addr_j1;
        x_wdata = a_q;
        if (x_ack) adv = 1'b1;
      end
      S_PASS_END: begin
        p_d = p_q - CW'(1);
`ifdef SORT_EARLY_EXIT_EN
        pass_stop = (p_d == '0) || !swp_q;
`else
        pass_stop = (p_d == '0);
`endif
        if (pass_stop) begin
          state_d = S_DONE;
        end else begin
          swp_d   = 1'b0;
          state_d = S_RD_A;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      j_d     = j_q + CW'(1);
      state_d = (j_d == p_q) ? S_PASS_END : S_RD_B;
    end
  end

  // Sequencer state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      p_q        <= '0;
      j_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      swp_q      <= 1'b0;
      swap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      p_q        <= p_d;
      j_q        <= j_d;
      a_q        <= a_d;
      b_q        <= b_d;
      swp_q      <= swp_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

endmodule

// File: tb/tb_sort_seq.sv
// Directed bench for sort_seq with a behavioural request/ack memory.
// Memory acks after ack_dly wait cycles; accesses are counted and bus stability is watched.
// Expected results are hand-computed sorted arrays, swap counts and cycle counts.
module tb_sort_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] base_i;
  logic [11:0] len_i;
  logic        busy, done;
  logic [15:0] swap_cnt;
  logic        mem_rq, mem_rnw;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  logic [15:0] mem [0:4095];
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, wr_cnt = 0, rq_seen = 0, stab_err = 0, gap_err = 0;
  int ack_dly = 0;
  int wcnt = 0;
  logic prev_ack = 1'b0;
  logic [11:0] h_addr;
  logic        h_rnw;
  logic [15:0] h_wd;

  sort_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base      (base_i),
    .len       (len_i),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt),
    .mem_rq    (mem_rq),
    .mem_rnw   (mem_rnw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // Memory responder, evaluated mid-cycle while the request is stable
  always @(negedge clk) begin
    if (mem_rq === 1'b1) begin
      rq_seen++;
      if (prev_ack) gap_err++;
      if (wcnt == 0) begin
        h_addr = mem_addr; h_rnw = mem_rnw; h_wd = mem_wdata;
      end else if (mem_addr !== h_addr || mem_rnw !== h_rnw || mem_wdata !== h_wd) begin
        stab_err++;
      end
      if (wcnt >= ack_dly) begin
        mem_ack = 1'b1;
        if (mem_rnw) begin
          mem_rdata = mem[mem_addr];
          rd_cnt++;
        end else begin
          mem[mem_addr] = mem_wdata;
          mem_rdata = 16'h0;
          wr_cnt++;
        end
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
    prev_ack = mem_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, wait for done (bounded), confirm single pulse and busy low after
  task automatic do_sort(input logic [11:0] b, input logic [11:0] l, output int ncyc);
    @(negedge clk);
    base_i = b; len_i = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncyc = 1;
    if (l >= 12'd2) check("busy_after_start", busy, 1'b1);
    while (done !== 1'b1 && ncyc < 5000) begin
      @(negedge clk);
      ncyc++;
    end
    check("done_seen", done, 1'b1);
    check("busy_during_done", busy, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  int n, rd0, wr0, rq0, k;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    mem_ack = 1'b0; mem_rdata = 16'h0;
    start = 1'b0; base_i = '0; len_i = '0;
    reset_n = 1'b0;
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_mem_rq", mem_rq, 1'b0);
    check("rst_mem_rnw", mem_rnw, 1'b0);
    check("rst_swap_cnt", swap_cnt, 16'h0);
    check("rst_mem_addr", mem_addr, 12'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic sort, zero wait: 3 passes, 5 swaps, 47 busy cycles then DONE
    mem[12'h100] = 16'd3; mem[12'h101] = 16'd1; mem[12'h102] = 16'd2; mem[12'h103] = 16'd0;
    ack_dly = 0;
    do_sort(12'h100, 12'd4, n);
    check("basic_m0", mem[12'h100], 16'd0);
    check("basic_m1", mem[12'h101], 16'd1);
    check("basic_m2", mem[12'h102], 16'd2);
    check("basic_m3", mem[12'h103], 16'd3);
    check("basic_swaps", swap_cnt, 16'd5);
    check("basic_cycles", n, 48);

    // Signed compare: 0x7FFF (max positive) > 0x8000 (min negative)
    mem[12'h200] = 16'h7FFF; mem[12'h201] = 16'h8000;
    do_sort(12'h200, 12'd2, n);
    check("signed_m0", mem[12'h200], 16'h8000);
    check("signed_m1", mem[12'h201], 16'h7FFF);
    check("signed_swaps", swap_cnt, 16'd1);

    // Degenerate lengths: done one cycle after the sampling edge, no requests
    for (k = 0; k < 2; k++) begin
      rq0 = rq_seen;
      do_sort(12'h500, 12'(k), n);
      check("degen_cycles", n, 1);
      check("degen_no_rq", rq_seen - rq0, 0);
      check("degen_swaps", swap_cnt, 16'd0);
    end

    // Already sorted
    mem[12'h400] = 16'd1; mem[12'h401] = 16'd2; mem[12'h402] = 16'd3; mem[12'h403] = 16'd4;
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_sort(12'h400, 12'd4, n);
`ifdef SORT_EARLY_EXIT_EN
    check("sorted_reads", rd_cnt - rd0, 4);
`else
    check("sorted_reads", rd_cnt - rd0, 9);
`endif
    check("sorted_writes", wr_cnt - wr0, 0);
    check("sorted_m0", mem[12'h400], 16'd1);
    check("sorted_m3", mem[12'h403], 16'd4);
    check("sorted_swaps", swap_cnt, 16'd0);

    // Wait states and address wrap
    ack_dly = 3; stab_err = 0; gap_err = 0;
    mem[12'hFFE] = 16'd5; mem[12'hFFF] = 16'd4; mem[12'h000] = 16'd6;
    do_sort(12'hFFE, 12'd3, n);
    check("wrap_m0", mem[12'hFFE], 16'd4);
    check("wrap_m1", mem[12'hFFF], 16'd5);
    check("wrap_m2", mem[12'h000], 16'd6);
    check("wrap_swaps", swap_cnt, 16'd1);
    check("wrap_stable", stab_err, 0);
    check("wrap_gap", gap_err, 0);

    // Reset abort during WR_HI of the first swap ([3,2,1] -> WR_LO leaves [2,2,1])
    mem[12'h300] = 16'd3; mem[12'h301] = 16'd2; mem[12'h302] = 16'd1;
    wr0 = wr_cnt;
    @(negedge clk);
    base_i = 12'h300; len_i = 12'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_rq === 1'b1 && mem_rnw === 1'b0 && wr_cnt == wr0 + 1) && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_wr_hi", k < 500, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_mem_rq", mem_rq, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_m0", mem[12'h300], 16'd2);
    check("abort_m1", mem[12'h301], 16'd2);
    @(negedge clk);
    reset_n = 1'b1;
    do_sort(12'h300, 12'd3, n);
    check("resort_m0", mem[12'h300], 16'd1);
    check("resort_m1", mem[12'h301], 16'd2);
    check("resort_m2", mem[12'h302], 16'd2);
    check("resort_swaps", swap_cnt, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sort_seq.md
# sort_seq

Memory-sequenced bubble-sort engine for the MU0 indexed core. It executes the bulk work behind the sort instruction: given a base address and element count from the index datapath, it reads, compares and swaps 16-bit signed words in main memory through a request/acknowledge memory port. It sits beside the main control FSM, which hands it `start` and stalls until `done`.

## Interface
- `AW`, 12: memory address width
- `DW`, 16: data word width
- `CW`, 12: element-count width

- `clk` in 1: system clock; all state updates on the rising edge
- `reset_n` in 1: one clock; reset is asynchronous and active-low
- `start` in 1: begin a sort; sampled only in IDLE
- `base` in AW: address of element 0; sampled with `start`
- `len` in CW: element count; sampled with `start`
- `busy` out 1: sort in progress
- `done` out 1: one-cycle completion pulse
- `swap_cnt` out 16: swaps performed in the current or last sort
- `mem_rq` out 1: memory request
- `mem_rnw` out 1: 1 = read, 0 = write
- `mem_addr` out AW: transaction address
- `mem_wdata` out DW: write data
- `mem_rdata` in DW: read data, valid when `mem_ack` is high
- `mem_ack` in 1: transaction complete

## Operation
- States are IDLE, RD_A, RD_B, CMP, WR_LO, WR_HI, PASS_END and DONE.
- **IDLE**
  - On `start`: latch `base` and `len`, clear `swap_cnt`, set pass limit p = len-1.
  - If `len < 2`, go to DONE. Otherwise go to RD_A.
- **RD_A:** read mem[base] into register A; set j = 0; go to RD_B.
- **RD_B:** read mem[base+j+1] into register B; go to CMP.
- **CMP** (one cycle, signed compare):
  - If A > B: set the swap flag, increment `swap_cnt` (saturating at 0xFFFF), go to WR_LO.
  - Otherwise: A <= B, then advance j.
- **WR_LO:** write B to base+j; go to WR_HI.
- **WR_HI:** write A to base+j+1. A keeps the larger value. Advance j.
- **Advance j:** j <= j+1. If j+1 == p, go to PASS_END; otherwise go to RD_B.
- **PASS_END:** p <= p-1. If the new p == 0, go to DONE; otherwise clear the swap flag and go to RD_A.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^AW; base+k wraps past the top of memory.
- `start` is ignored outside IDLE.
- Reset values:
  - state = IDLE.
  - `busy`, `done`, `mem_rq`, `mem_rnw`: all 0.
  - `swap_cnt` and `mem_addr`: all 0.
  - `mem_wdata`: all 0.
- Reset mid-operation aborts at once: `mem_rq` drops asynchronously. Memory may be left partially sorted but holds no corrupted words beyond a completed write.

## Timing
- `busy` is 1 in every state except IDLE and DONE. It rises in the cycle after `start` is sampled.
- **Memory handshake**
  - While `mem_rq` = 1, `mem_addr`, `mem_rnw` and `mem_wdata` are held stable until `mem_ack` is sampled high.
  - `mem_ack` may arrive in the first `mem_rq` cycle (zero wait).
  - Read data is captured in the `mem_ack` cycle.
  - `mem_rq` is 0 for at least one cycle after each `mem_ack`. A transaction therefore takes at least 2 cycles.
  - `mem_ack` while `mem_rq` = 0 is ignored.
- **Latency**
  - `start` to `done` with `len < 2`: 2 cycles (IDLE→DONE→pulse). `mem_rq` is never raised.
  - With zero-wait memory: each non-swapping compare costs 3 cycles (RD_B, CMP); each swapping compare costs 7 cycles.

## Configuration
- Macro: `SORT_EARLY_EXIT_EN`.
- Defined: PASS_END also goes to DONE when the swap flag is clear, so a pass with no swaps ends the sort.
- Undefined: all len-1 passes always run. Results are identical; only the memory traffic differs.

## Structure
- Shared package `mu0_defs` holds:
  - the state encoding localparams;
  - the `mem_rnw` encoding constants;
  - the AW/DW defaults used by the core.
- One sub-module is natural: `sort_mem_xfer`. It owns the `mem_rq`/`mem_ack` handshake, the address/data hold registers and the post-ack idle cycle. It presents a single-pulse `go`/`ack` interface to the sequencer.

## Test plan
- **Basic sort:** base=0x100, len=4, mem=[3,1,2,0], zero-wait memory → mem=[0,1,2,3], `swap_cnt`=5, exactly one `done` pulse, `busy` low after it.
- **Signed compare:** len=2, mem=[0x7FFF,0x8000] → mem=[0x8000,0x7FFF], `swap_cnt`=1.
- **Degenerate lengths:** len=0 and len=1 → `done` 2 cycles after `start`, no `mem_rq` asserted, `swap_cnt`=0.
- **Already sorted:** mem=[1,2,3,4].
  - With `SORT_EARLY_EXIT_EN`: 4 reads, 0 writes.
  - Without it: 9 reads, 0 writes.
  - Final contents are unchanged in both cases.
- **Wait states and wrap:** `mem_ack` delayed 3 cycles on every transaction, base=0xFFE, len=3, mem[0xFFE,0xFFF,0x000]=[5,4,6].
  - Address and data stay stable throughout each request.
  - Result is [4,5,6] with correct wrap to 0x000.
- **Reset abort:** `reset_n` pulsed low during WR_HI.
  - `mem_rq`, `busy` and `done` go to 0 immediately.
  - A subsequent `start` completes a correct sort.
